// File: rtl/mesh_core_injector.sv
// Core-side mesh transmitter: stamps source coordinates and a sequence number onto
// core requests and queues them in a show-ahead FIFO feeding the router core input.
module mesh_core_injector #(
    parameter int X       = 0,
    parameter int Y       = 0,
    parameter int COORD_W = 4,
    parameter int DATA_W  = 32,
    parameter int SEQ_W   = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [COORD_W-1:0]         req_dest_x,
    input  logic [COORD_W-1:0]         req_dest_y,
    input  logic [DATA_W-1:0]          req_data,
    output logic                       pkt_valid,
    input  logic                       pkt_ready,
    output logic [COORD_W-1:0]         pkt_dest_x,
    output logic [COORD_W-1:0]         pkt_dest_y,
    output logic [COORD_W-1:0]         pkt_src_x,
    output logic [COORD_W-1:0]         pkt_src_y,
    output logic [SEQ_W-1:0]           pkt_seq,
    output logic [DATA_W-1:0]          pkt_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                tx_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [COORD_W-1:0] dx_r   [DEPTH];
    logic [COORD_W-1:0] dy_r   [DEPTH];
    logic [SEQ_W-1:0]   seq_e_r[DEPTH];
    logic [DATA_W-1:0]  data_r [DEPTH];

    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [SEQ_W-1:0] seq_r;
    logic [15:0]      tx_count_r;

    logic full_s;
    logic empty_s;
    logic accept_s;
    logic send_s;

    // Handshake qualifiers; readiness depends only on occupancy so a full FIFO never passes through.
    assign full_s   = (count_r == CW'(DEPTH));
    assign empty_s  = (count_r == CW'(0));
    assign req_ready = !rst && !full_s;
    assign pkt_valid = !empty_s;
    assign accept_s = req_valid && req_ready;
    assign send_s   = pkt_valid && pkt_ready;

    assign pkt_dest_x = dx_r[rd_ptr_r];
    assign pkt_dest_y = dy_r[rd_ptr_r];
    assign pkt_seq    = seq_e_r[rd_ptr_r];
    assign pkt_data   = data_r[rd_ptr_r];
    assign pkt_src_x  = COORD_W'(X);
    assign pkt_src_y  = COORD_W'(Y);
    assign count      = count_r;
    assign tx_count   = tx_count_r;

    // FIFO storage, pointers, occupancy, sequence and transmit counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dx_r[i]    <= COORD_W'(0);
                dy_r[i]    <= COORD_W'(0);
                seq_e_r[i] <= SEQ_W'(0);
                data_r[i]  <= DATA_W'(0);
            end
            wr_ptr_r   <= PW'(0);
            rd_ptr_r   <= PW'(0);
            count_r    <= CW'(0);
            seq_r      <= SEQ_W'(0);
            tx_count_r <= 16'd0;
        end else begin
            if (accept_s) begin
                dx_r[wr_ptr_r]    <= req_dest_x;
                dy_r[wr_ptr_r]    <= req_dest_y;
                seq_e_r[wr_ptr_r] <= seq_r;
                data_r[wr_ptr_r]  <= req_data;
                wr_ptr_r          <= wr_ptr_r + PW'(1);
                seq_r             <= seq_r + SEQ_W'(1);
            end
            if (send_s) begin
                rd_ptr_r   <= rd_ptr_r + PW'(1);
                tx_count_r <= tx_count_r + 16'd1;
            end
            case ({accept_s, send_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule
